persiana_planta: RTL and testbench

Behavioural-synthesizable plant model of the motorized blind. It drives the other end of the blind-controller interface: it consumes motor commands subir/bajar and produces the limit/position sensor signals Ssup, Smed, Sinf that the controller FSM reads. Used on-chip as a loopback plant for demo mode and in benches as the closed-loop partner of the controller. Position advances one step per prescaled tick.

---
 rtl/persiana_planta.sv | 148 ++++++++++++++
 tb/tb_persiana_planta.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/persiana_planta.sv
// Plant model of a motorized blind, used as the loopback partner of the blind controller.
// It takes the motor commands subir/bajar and produces the limit/mid sensors that the
// controller reads. Position moves one step per prescaled tick.
//
// Optional feature: define STALL_DETECT_EN to fault after STALL_TICKS consecutive ticks
// of driving against an end stop. Without it, driving against a stop saturates forever.
//
// Ports:
//   clk       in   system clock
//   reseteo   in   asynchronous, active-high reset
//   ena       in   1 = prescaler and FSM run; 0 = everything holds
//   subir     in   motor up command
//   bajar     in   motor down command
//   Ssup      out  upper limit sensor (posicion == TRAVEL_TICKS)
//   Smed      out  mid sensor (posicion within MID_POS +/- MID_WIN)
//   Sinf      out  lower limit sensor (posicion == 0)
//   posicion  out  current position, 0..TRAVEL_TICKS
//   moviendo  out  1 while moving up or down
//   falla     out  sticky fault flag, cleared only by reset
module persiana_planta #(
  parameter int unsigned PRESCALE     = 4,
  parameter int unsigned TRAVEL_TICKS = 20,
  parameter int unsigned MID_POS      = 10,
  parameter int unsigned MID_WIN      = 1,
  parameter int unsigned POS_INIT     = 0,
  parameter int unsigned STALL_TICKS  = 3
) (
  input  logic       clk,
  input  logic       reseteo,
  input  logic       ena,
  input  logic       subir,
  input  logic       bajar,
  output logic       Ssup,
  output logic       Smed,
  output logic       Sinf,
  output logic [7:0] posicion,
  output logic       moviendo,
  output logic       falla
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(PRESCALE - 1);
  localparam logic [7:0] TravelPos = TRAVEL_TICKS[7:0];
  localparam logic [7:0] InitPos   = POS_INIT[7:0];
  localparam int MidLo = int'(MID_POS) - int'(MID_WIN);
  localparam int MidHi = int'(MID_POS) + int'(MID_WIN);

  typedef enum logic [1:0] {
    StReposo,
    StSubiendo,
    StBajando,
    StFalla
  } estado_e;

  estado_e       estado_q, estado_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    pos_q, pos_d;
  logic          tick;
  int            pos_int;

  assign tick = ena && (presc_q == PrescMax);

`ifdef STALL_DETECT_EN
  localparam int unsigned SW = $clog2(STALL_TICKS + 1);
  localparam logic [SW-1:0] StallMax = SW'(STALL_TICKS);

  logic [SW-1:0] stall_q, stall_d;
  logic          en_tope;

  // Pushing against the stop in the direction of travel with only that command held.
  always_comb begin
    en_tope = 1'b0;
    if (estado_q == StSubiendo && subir && !bajar && pos_q == TravelPos) en_tope = 1'b1;
    if (estado_q == StBajando && bajar && !subir && pos_q == 8'd0)      en_tope = 1'b1;
  end

  always_comb begin
    stall_d = stall_q;
    if (tick) stall_d = en_tope ? stall_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) stall_q <= '0;
    else         stall_q <= stall_d;
  end
`else
  logic unused_stall_ticks;
  assign unused_stall_ticks = ^STALL_TICKS;
`endif

  always_comb begin
    presc_d  = presc_q;
    estado_d = estado_q;
    pos_d    = pos_q;

    if (ena) presc_d = (presc_q == PrescMax) ? '0 : presc_q + 1'b1;

    if (tick) begin
      unique case (estado_q)
        StReposo: begin
          // Entry tick only changes state; motion starts on the following tick.
          if (subir && bajar)                   estado_d = StFalla;
          else if (subir && pos_q < TravelPos)  estado_d = StSubiendo;
          else if (bajar && pos_q != 8'd0)      estado_d = StBajando;
        end
        StSubiendo: begin
          if (subir && bajar) estado_d = StFalla;
          else if (subir) begin
            if (pos_q < TravelPos) pos_d = pos_q + 8'd1;
          end else estado_d = StReposo;
        end
        StBajando: begin
          if (subir && bajar) estado_d = StFalla;
          else if (bajar) begin
            if (pos_q != 8'd0) pos_d = pos_q - 8'd1;
          end else estado_d = StReposo;
        end
        StFalla: estado_d = StFalla;
        default: estado_d = StFalla;
      endcase
`ifdef STALL_DETECT_EN
      if (en_tope && stall_d >= StallMax) estado_d = StFalla;
`endif
    end
  end

  always_ff @(posedge clk or posedge reseteo) begin
    if (reseteo) begin
      presc_q  <= '0;
      estado_q <= StReposo;
      pos_q    <= InitPos;
    end else begin
      presc_q  <= presc_d;
      estado_q <= estado_d;
      pos_q    <= pos_d;
    end
  end

  // All outputs decode from registered state so subir/bajar never reach them directly.
  assign pos_int  = int'(pos_q);
  assign posicion = pos_q;
  assign Ssup     = (pos_q == TravelPos);
  assign Sinf     = (pos_q == 8'd0);
  assign Smed     = (pos_int >= MidLo) && (pos_int <= MidHi);
  assign moviendo = (estado_q == StSubiendo) || (estado_q == StBajando);
  assign falla    = (estado_q == StFalla);

endmodule

// File: tb/tb_persiana_planta.sv
module tb_persiana_planta;

  logic       clk = 1'b0;
  logic       reseteo, ena, subir, bajar;
  logic       Ssup, Smed, Sinf, moviendo, falla;
  logic [7:0] posicion;

  int nchecks = 0;
  int nerrors = 0;
  int cyc = 0;

  persiana_planta dut (
    .clk      (clk),
    .reseteo  (reseteo),
    .ena      (ena),
    .subir    (subir),
    .bajar    (bajar),
    .Ssup     (Ssup),
    .Smed     (Smed),
    .Sinf     (Sinf),
    .posicion (posicion),
    .moviendo (moviendo),
    .falla    (falla)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Inputs change and outputs are sampled on the falling edge; cyc counts rising edges
  // since reset release.
  task automatic hasta(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reseteo = 1'b1;
    ena     = 1'b1;
    subir   = 1'b0;
    bajar   = 1'b0;
    repeat (2) @(negedge clk);
    reseteo = 1'b0;
    cyc     = 0;
  endtask

  task automatic test_reset();
    reseteo = 1'b1;
    ena = 1'b1; subir = 1'b0; bajar = 1'b0;
    #1;
    nchecks++;
    if (posicion !== 8'd0) begin
      nerrors++; $display("FAIL reset_pos: got %0d expected 0", posicion);
    end
    nchecks++;
    if ({Sinf, Ssup, Smed} !== 3'b100) begin
      nerrors++; $display("FAIL reset_sensors: got %b expected 100", {Sinf, Ssup, Smed});
    end
    nchecks++;
    if ({moviendo, falla} !== 2'b00) begin
      nerrors++; $display("FAIL reset_flags: got %b expected 00", {moviendo, falla});
    end
    do_reset();
  endtask

  task automatic test_subida();
    logic exp_med;
    do_reset();
    subir = 1'b1;
    hasta(3);
    nchecks++;
    if (moviendo !== 1'b0) begin
      nerrors++; $display("FAIL up_pre_tick: moviendo got %b expected 0", moviendo);
    end
    hasta(4);
    nchecks++;
    if (moviendo !== 1'b1 || posicion !== 8'd0) begin
      nerrors++;
      $display("FAIL up_first_tick: moviendo/pos got %b/%0d expected 1/0", moviendo, posicion);
    end
    for (int n = 1; n <= 20; n++) begin
      hasta(4 * (n + 1));
      exp_med = (n >= 9 && n <= 11);
      nchecks++;
      if (posicion !== 8'(n) || Smed !== exp_med || Ssup !== (n == 20) || Sinf !== 1'b0) begin
        nerrors++;
        $display("FAIL up_pos%0d: pos=%0d Smed=%b Ssup=%b Sinf=%b expected pos=%0d Smed=%b Ssup=%b Sinf=0",
                 n, posicion, Smed, Ssup, Sinf, n, exp_med, (n == 20));
      end
    end
`ifdef STALL_DETECT_EN
    hasta(92);
    nchecks++;
    if (falla !== 1'b0) begin
      nerrors++; $display("FAIL stall_2nd: falla got %b expected 0", falla);
    end
    hasta(96);
    nchecks++;
    if (falla !== 1'b1 || moviendo !== 1'b0 || posicion !== 8'd20) begin
      nerrors++;
      $display("FAIL stall_3rd: falla/mov/pos got %b/%b/%0d expected 1/0/20", falla, moviendo, posicion);
    end
`else
    hasta(84 + 4 * 50);
    nchecks++;
    if (falla !== 1'b0 || moviendo !== 1'b1 || posicion !== 8'd20 || Ssup !== 1'b1) begin
      nerrors++;
      $display("FAIL saturate: falla/mov/pos/Ssup got %b/%b/%0d/%b expected 0/1/20/1",
               falla, moviendo, posicion, Ssup);
    end
`endif
  endtask

  task automatic test_reset_mid();
    do_reset();
    subir = 1'b1;
    hasta(32);
    nchecks++;
    if (posicion !== 8'd7) begin
      nerrors++; $display("FAIL mid_pre: pos got %0d expected 7", posicion);
    end
    reseteo = 1'b1;
    #1;
    nchecks++;
    if (posicion !== 8'd0 || {Sinf, Ssup, Smed} !== 3'b100 || {moviendo, falla} !== 2'b00) begin
      nerrors++;
      $display("FAIL mid_reset: pos=%0d sens=%b flags=%b expected 0/100/00",
               posicion, {Sinf, Ssup, Smed}, {moviendo, falla});
    end
    reseteo = 1'b0;
  endtask

  task automatic test_reversa();
    do_reset();
    subir = 1'b1;
    hasta(64);
    nchecks++;
    if (posicion !== 8'd15) begin
      nerrors++; $display("FAIL rev_pre: pos got %0d expected 15", posicion);
    end
    subir = 1'b0; bajar = 1'b1;
    hasta(66);
    nchecks++;
    if (moviendo !== 1'b1) begin
      nerrors++; $display("FAIL rev_between: moviendo got %b expected 1", moviendo);
    end
    hasta(68);
    nchecks++;
    if (moviendo !== 1'b0 || posicion !== 8'd15) begin
      nerrors++; $display("FAIL rev_reposo: mov/pos got %b/%0d expected 0/15", moviendo, posicion);
    end
    hasta(72);
    nchecks++;
    if (moviendo !== 1'b1 || posicion !== 8'd15) begin
      nerrors++; $display("FAIL rev_bajando: mov/pos got %b/%0d expected 1/15", moviendo, posicion);
    end
    hasta(76);
    nchecks++;
    if (posicion !== 8'd14) begin
      nerrors++; $display("FAIL rev_step: pos got %0d expected 14", posicion);
    end
  endtask

  task automatic test_falla();
    do_reset();
    subir = 1'b1;
    hasta(24);
    bajar = 1'b1;
    hasta(26);
    nchecks++;
    if (posicion !== 8'd5 || falla !== 1'b0) begin
      nerrors++; $display("FAIL flt_pre: pos/falla got %0d/%b expected 5/0", posicion, falla);
    end
    hasta(28);
    nchecks++;
    if (falla !== 1'b1 || moviendo !== 1'b0 || posicion !== 8'd5) begin
      nerrors++;
      $display("FAIL flt_enter: falla/mov/pos got %b/%b/%0d expected 1/0/5", falla, moviendo, posicion);
    end
    for (int k = 1; k <= 10; k++) begin
      subir = k[0];
      bajar = k[1];
      hasta(28 + 4 * k);
      nchecks++;
      if (falla !== 1'b1 || moviendo !== 1'b0 || posicion !== 8'd5 || Sinf !== 1'b0) begin
        nerrors++;
        $display("FAIL flt_hold%0d: falla/mov/pos/Sinf got %b/%b/%0d/%b expected 1/0/5/0",
                 k, falla, moviendo, posicion, Sinf);
      end
    end
    reseteo = 1'b1;
    #1;
    nchecks++;
    if (falla !== 1'b0 || posicion !== 8'd0) begin
      nerrors++; $display("FAIL flt_clear: falla/pos got %b/%0d expected 0/0", falla, posicion);
    end
    reseteo = 1'b0;
  endtask

  task automatic test_ena();
    do_reset();
    subir = 1'b1;
    hasta(10);
    ena = 1'b0;
    hasta(15);
    nchecks++;
    if (posicion !== 8'd1 || moviendo !== 1'b1) begin
      nerrors++; $display("FAIL ena_frozen: pos/mov got %0d/%b expected 1/1", posicion, moviendo);
    end
    hasta(20);
    ena = 1'b1;
    hasta(21);
    nchecks++;
    if (posicion !== 8'd1) begin
      nerrors++; $display("FAIL ena_resume_early: pos got %0d expected 1", posicion);
    end
    hasta(22);
    nchecks++;
    if (posicion !== 8'd2) begin
      nerrors++; $display("FAIL ena_resume_tick: pos got %0d expected 2", posicion);
    end
    hasta(26);
    nchecks++;
    if (posicion !== 8'd3) begin
      nerrors++; $display("FAIL ena_next_tick: pos got %0d expected 3", posicion);
    end
  endtask

  initial begin
    test_reset();
    test_subida();
    test_reset_mid();
    test_reversa();
    test_falla();
    test_ena();
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
